// File: rtl/player_ctrl.sv
// player_ctrl: keyboard-driven tile movement for two players.
// Press events become per-player pending requests; a two-state FSM
// (IDLE -> EVAL) services one request every two cycles, round-robin
// between A and B, and commits or rejects the move against arena bounds,
// the walkAble bitmap and the other player's tile.
// Optional feature: define KEY_AUTOREPEAT_EN to generate repeat requests
// while a direction key stays held.
module player_ctrl #(
  parameter int HMAXTILE = 9,
  parameter int VMAXTILE = 5,
  parameter int COOLDOWN = 5_000_000,
  parameter int REPEAT   = 20_000_000
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [511:0]                         key_down,
  input  logic [8:0]                           last_change,
  input  logic                                 been_ready,
  input  logic [(HMAXTILE+1)*(VMAXTILE+1):0]   walkAble,
  output logic [3:0]                           curAh,
  output logic [3:0]                           curAv,
  output logic [3:0]                           curBh,
  output logic [3:0]                           curBv,
  output logic                                 movedA,
  output logic                                 movedB,
  output logic                                 bumpA,
  output logic                                 bumpB
);
  localparam int WW = (HMAXTILE+1)*(VMAXTILE+1)+1;
  localparam int IW = $clog2(WW);
  localparam logic [1:0] DirUp = 2'd0, DirDn = 2'd1, DirLf = 2'd2, DirRt = 2'd3;

  typedef enum logic {IDLE, EVAL} state_t;
  state_t state, stateNext;

  // index 0 = player A, 1 = player B
  logic [1:0]        pend;
  logic [1:0][1:0]   dir;
  logic [1:0][22:0]  cd;
  logic              prio;
  logic              selP;
  logic [3:0]        tgtH, tgtV;
  logic              tgtOor;

  logic [1:0]        keyHit, reqHit, elig, commit;
  logic [1:0][1:0]   keyDir, reqDir;
  logic              start, selNext, bumpNow, nxtOor;
  logic [3:0]        nxtH, nxtV;
  logic [4:0]        th, tv;
  logic [IW-1:0]     idx;

  // Decode a fresh press of a mapped key into player + direction
  always_comb begin
    keyHit = '0;
    keyDir = '0;
    if (been_ready && key_down[last_change]) begin
      case (last_change)
        9'h01D: begin keyHit[0] = 1'b1; keyDir[0] = DirUp; end
        9'h01B: begin keyHit[0] = 1'b1; keyDir[0] = DirDn; end
        9'h01C: begin keyHit[0] = 1'b1; keyDir[0] = DirLf; end
        9'h023: begin keyHit[0] = 1'b1; keyDir[0] = DirRt; end
        9'h175: begin keyHit[1] = 1'b1; keyDir[1] = DirUp; end
        9'h172: begin keyHit[1] = 1'b1; keyDir[1] = DirDn; end
        9'h16B: begin keyHit[1] = 1'b1; keyDir[1] = DirLf; end
        9'h174: begin keyHit[1] = 1'b1; keyDir[1] = DirRt; end
        default: ;
      endcase
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT+1);
  logic [1:0]         held, rptFire;
  logic [1:0][1:0]    heldDir;
  logic [1:0][RW-1:0] rptCnt;

  // Held-key direction per player; later tests win, giving up > down > left > right
  always_comb begin
    held    = '0;
    heldDir = '0;
    if (key_down[9'h023]) begin held[0] = 1'b1; heldDir[0] = DirRt; end
    if (key_down[9'h01C]) begin held[0] = 1'b1; heldDir[0] = DirLf; end
    if (key_down[9'h01B]) begin held[0] = 1'b1; heldDir[0] = DirDn; end
    if (key_down[9'h01D]) begin held[0] = 1'b1; heldDir[0] = DirUp; end
    if (key_down[9'h174]) begin held[1] = 1'b1; heldDir[1] = DirRt; end
    if (key_down[9'h16B]) begin held[1] = 1'b1; heldDir[1] = DirLf; end
    if (key_down[9'h172]) begin held[1] = 1'b1; heldDir[1] = DirDn; end
    if (key_down[9'h175]) begin held[1] = 1'b1; heldDir[1] = DirUp; end
    for (int p = 0; p < 2; p++) begin
      rptFire[p] = held[p] && !pend[p] && (rptCnt[p] == RW'(REPEAT-1));
      reqHit[p]  = keyHit[p] | rptFire[p];
      reqDir[p]  = keyHit[p] ? keyDir[p] : heldDir[p];
    end
  end

  // Repeat interval restarts on every press, commit, release or pending request
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (rst || keyHit[p] || commit[p] || !held[p] || pend[p] || rptFire[p])
        rptCnt[p] <= '0;
      else
        rptCnt[p] <= rptCnt[p] + 1'b1;
    end
  end
`else
  // Only fresh press events generate requests
  always_comb begin
    reqHit = keyHit;
    reqDir = keyDir;
  end
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next state, arbitration and move evaluation
  always_comb begin
    stateNext = state;
    start     = 1'b0;
    selNext   = 1'b0;
    bumpNow   = 1'b0;
    commit    = '0;
    idx       = IW'(tgtV * (HMAXTILE+1)) + IW'(tgtH);
    for (int p = 0; p < 2; p++) elig[p] = pend[p] && (cd[p] == '0);
    case (state)
      IDLE: if (|elig) begin
        start     = 1'b1;
        stateNext = EVAL;
        selNext   = (&elig) ? prio : elig[1];
      end
      EVAL: begin
        stateNext = IDLE;
        bumpNow   = tgtOor || !walkAble[idx] ||
                    (selP ? (tgtH == curAh && tgtV == curAv)
                          : (tgtH == curBh && tgtV == curBv));
        commit[selP] = !bumpNow;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Target tile for the player about to be selected, in 5-bit signed space
  always_comb begin
    th = {1'b0, selNext ? curBh : curAh};
    tv = {1'b0, selNext ? curBv : curAv};
    case (dir[selNext])
      DirUp:   tv = tv - 5'd1;
      DirDn:   tv = tv + 5'd1;
      DirLf:   th = th - 5'd1;
      default: th = th + 5'd1;
    endcase
    nxtOor = th[4] || tv[4] || (th > 5'(HMAXTILE)) || (tv > 5'(VMAXTILE));
    // out-of-range targets keep the current tile so the bitmap index stays valid
    nxtH = nxtOor ? (selNext ? curBh : curAh) : th[3:0];
    nxtV = nxtOor ? (selNext ? curBv : curAv) : tv[3:0];
  end

  // Positions, pulses, pending requests, cooldowns and arbitration pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      curAh <= '0; curAv <= '0;
      curBh <= 4'(HMAXTILE); curBv <= 4'(VMAXTILE);
      movedA <= 1'b0; movedB <= 1'b0; bumpA <= 1'b0; bumpB <= 1'b0;
      pend <= '0; dir <= '0; cd <= '0; prio <= 1'b0;
      selP <= 1'b0; tgtH <= '0; tgtV <= '0; tgtOor <= 1'b0;
    end else begin
      movedA <= commit[0];
      movedB <= commit[1];
      bumpA  <= bumpNow && !selP;
      bumpB  <= bumpNow && selP;
      if (commit[0]) begin curAh <= tgtH; curAv <= tgtV; end
      if (commit[1]) begin curBh <= tgtH; curBv <= tgtV; end
      if (start) begin
        selP   <= selNext;
        tgtH   <= nxtH;
        tgtV   <= nxtV;
        tgtOor <= nxtOor;
        prio   <= !selNext;
      end
      for (int p = 0; p < 2; p++) begin
        if (commit[p])       cd[p] <= 23'(COOLDOWN);
        else if (cd[p] != 0) cd[p] <= cd[p] - 1'b1;
        // the request is consumed when latched, so a press landing in the
        // latch or EVAL cycle becomes a new pending request
        if (reqHit[p]) begin
          pend[p] <= 1'b1;
          dir[p]  <= reqDir[p];
        end else if (start && selNext == 1'(p)) begin
          pend[p] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_player_ctrl.sv
// tb_player_ctrl: directed stimulus, a per-cycle behavioural model of the
// movement rules compared on every falling edge, plus literal expectations.
module tb_player_ctrl;
  localparam int H  = 9;
  localparam int V  = 5;
  localparam int CD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [511:0] key_down = '0;
  logic [8:0]   last_change = '0;
  logic         been_ready = 1'b0;
  logic [(H+1)*(V+1):0] walkAble = '1;
  logic [3:0] curAh, curAv, curBh, curBv;
  logic movedA, movedB, bumpA, bumpB;

  int checks = 0;
  int failures = 0;

  player_ctrl #(.HMAXTILE(H), .VMAXTILE(V), .COOLDOWN(CD), .REPEAT(20)) dut (
    .clk(clk), .rst(rst), .key_down(key_down), .last_change(last_change),
    .been_ready(been_ready), .walkAble(walkAble),
    .curAh(curAh), .curAv(curAv), .curBh(curBh), .curBv(curBv),
    .movedA(movedA), .movedB(movedB), .bumpA(bumpA), .bumpB(bumpB)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // key table order: A up/down/left/right, then B up/down/left/right
  logic [8:0] keyTab [8] = '{9'h01D, 9'h01B, 9'h01C, 9'h023,
                             9'h175, 9'h172, 9'h16B, 9'h174};
  int mPos [2][2];            // [player][0=h,1=v]
  bit mPend [2];
  int mDir [2];
  int mCd [2];
  int mPrio, mSel, mSelDir;
  bit mBusy;
  bit mMoved [2];
  bit mBump [2];
  bit mLive = 1'b0;

  task automatic modelStep();
    int th, tv, o;
    bit ok;
    bit com [2];
    bit e0, e1;
    com = '{1'b0, 1'b0};
    if (rst) begin
      mPos[0] = '{0, 0}; mPos[1] = '{H, V};
      mPend = '{1'b0, 1'b0}; mCd = '{0, 0}; mDir = '{0, 0};
      mPrio = 0; mBusy = 1'b0; mSel = 0; mSelDir = 0;
      mMoved = '{1'b0, 1'b0}; mBump = '{1'b0, 1'b0};
      mLive = 1'b1;
      return;
    end
    mMoved = '{1'b0, 1'b0};
    mBump  = '{1'b0, 1'b0};
    if (mBusy) begin
      o  = 1 - mSel;
      th = mPos[mSel][0];
      tv = mPos[mSel][1];
      case (mSelDir)
        0: tv = tv - 1;
        1: tv = tv + 1;
        2: th = th - 1;
        default: th = th + 1;
      endcase
      ok = (th >= 0) && (th <= H) && (tv >= 0) && (tv <= V);
      if (ok) ok = walkAble[tv*(H+1)+th];
      if (ok && th == mPos[o][0] && tv == mPos[o][1]) ok = 1'b0;
      if (ok) begin
        mPos[mSel][0] = th; mPos[mSel][1] = tv;
        mMoved[mSel] = 1'b1; com[mSel] = 1'b1;
      end else begin
        mBump[mSel] = 1'b1;
      end
      mBusy = 1'b0;
    end else begin
      e0 = mPend[0] && mCd[0] == 0;
      e1 = mPend[1] && mCd[1] == 0;
      if (e0 || e1) begin
        mSel = (e0 && e1) ? mPrio : (e0 ? 0 : 1);
        mSelDir = mDir[mSel];
        mPend[mSel] = 1'b0;
        mPrio = 1 - mSel;
        mBusy = 1'b1;
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (com[p]) mCd[p] = CD;
      else if (mCd[p] > 0) mCd[p] = mCd[p] - 1;
    end
    if (been_ready && key_down[last_change]) begin
      for (int k = 0; k < 8; k++) begin
        if (keyTab[k] == last_change) begin
          mPend[k/4] = 1'b1;
          mDir[k/4]  = k % 4;
        end
      end
    end
  endtask

  // compare DUT against the prediction for the edge just past, then predict the next
  always @(negedge clk) begin
    if (mLive) begin
      chk("cmp.curAh", int'(curAh), mPos[0][0]);
      chk("cmp.curAv", int'(curAv), mPos[0][1]);
      chk("cmp.curBh", int'(curBh), mPos[1][0]);
      chk("cmp.curBv", int'(curBv), mPos[1][1]);
      chk("cmp.movedA", int'(movedA), int'(mMoved[0]));
      chk("cmp.movedB", int'(movedB), int'(mMoved[1]));
      chk("cmp.bumpA", int'(bumpA), int'(mBump[0]));
      chk("cmp.bumpB", int'(bumpB), int'(mBump[1]));
    end
    modelStep();
  end

  // ---------------- stimulus ----------------
  // called at posedge+1; drives one press cycle and returns at the next posedge+1
  task automatic press(input logic [8:0] c);
    last_change = c;
    key_down[c] = 1'b1;
    been_ready  = 1'b1;
    @(posedge clk); #1;
    been_ready  = 1'b0;
    key_down[c] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    chk("reset.curAh", int'(curAh), 0);
    chk("reset.curAv", int'(curAv), 0);
    chk("reset.curBh", int'(curBh), 9);
    chk("reset.curBv", int'(curBv), 5);
    chk("reset.pulses", int'({movedA, movedB, bumpA, bumpB}), 0);

    // A at (0,0) presses up -> bump; press right 4 cycles later moves at once
    press(9'h01D);
    idle(2);
    chk("edge.bumpA", int'(bumpA), 1);
    chk("edge.curAv", int'(curAv), 0);
    idle(1);
    press(9'h023);
    idle(2);
    chk("move.movedA", int'(movedA), 1);
    chk("move.curAh", int'(curAh), 1);
    idle(1);
    chk("move.pulse1", int'(movedA), 0);
    idle(11);

    // tile 11 blocked: A at (1,0) down -> bump
    walkAble[11] = 1'b0;
    press(9'h01B);
    idle(2);
    chk("wall.bumpA", int'(bumpA), 1);
    chk("wall.curAv", int'(curAv), 0);
    walkAble[11] = 1'b1;
    idle(4);

    // contention after B bump: A wins (priority back on A)
    press(9'h174);
    press(9'h01B);
    press(9'h16B);
    chk("pairX.bumpB", int'(bumpB), 1);
    idle(2);
    chk("pairX.movedA", int'(movedA), 1);
    chk("pairX.curAv", int'(curAv), 1);
    chk("pairX.movedB0", int'(movedB), 0);
    idle(2);
    chk("pairX.movedB", int'(movedB), 1);
    chk("pairX.curBh", int'(curBh), 8);
    idle(12);

    // contention after A bump: B wins
    walkAble[10] = 1'b0;
    press(9'h01C);
    press(9'h175);
    press(9'h01B);
    chk("pairY.bumpA", int'(bumpA), 1);
    walkAble[10] = 1'b1;
    idle(2);
    chk("pairY.movedB", int'(movedB), 1);
    chk("pairY.curBv", int'(curBv), 4);
    chk("pairY.movedA0", int'(movedA), 0);
    idle(2);
    chk("pairY.movedA", int'(movedA), 1);
    chk("pairY.curAv", int'(curAv), 2);
    idle(12);

    // cooldown: second press during reload waits for the counter
    press(9'h023);
    idle(1);
    press(9'h023);
    chk("cool.first", int'(curAh), 2);
    idle(9);
    chk("cool.held", int'(curAh), 2);
    chk("cool.noPulse", int'(movedA), 0);
    idle(1);
    chk("cool.movedA", int'(movedA), 1);
    chk("cool.curAh", int'(curAh), 3);
    idle(12);

    // reset, walk B to (1,0), then A collides
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin press(9'h175); idle(12); end
    for (int i = 0; i < 8; i++) begin press(9'h16B); idle(12); end
    chk("walk.curBh", int'(curBh), 1);
    chk("walk.curBv", int'(curBv), 0);
    press(9'h023);
    idle(2);
    chk("coll.bumpA", int'(bumpA), 1);
    chk("coll.curAh", int'(curAh), 0);

    // reset during EVAL discards the move
    press(9'h01B);
    idle(1);
    rst = 1'b1;
    idle(1);
    chk("rstEval.curAv", int'(curAv), 0);
    chk("rstEval.curBh", int'(curBh), 9);
    chk("rstEval.movedA", int'(movedA), 0);
    rst = 1'b0;
    idle(4);
    chk("rstEval.after", int'(movedA), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
